// File: rtl/iiitb_icg_ctrl_pkg.sv
// iiitb_icg_ctrl_pkg: shared channel state encoding and default sizing for the gating controller
package iiitb_icg_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, GATED = 2'b01, WAKE = 2'b10} state_e;
  localparam int DEF_N_CH = 4;
  localparam int DEF_IDLE_W = 8;
  localparam int DEF_WAKE_CYC = 2;
  localparam int DEF_EVT_W = 16;
endpackage

// File: rtl/iiitb_icg_cell.sv
// iiitb_icg_cell: glitch-free latch-based clock gate; reset opens the gate so clocks run out of reset
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);
  logic en_q;
  always_latch
    if (!rst_n) en_q <= 1'b1;
    else if (!clk) en_q <= en;
  assign gclk = clk & en_q;
endmodule

// File: rtl/iiitb_icg_ctrl.sv
// iiitb_icg_ctrl: per-channel idle-timeout clock gating with timed wake and saturating gate-event count
module iiitb_icg_ctrl
  import iiitb_icg_ctrl_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int EVT_W    = DEF_EVT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   busy,
  input  logic [N_CH-1:0]   force_on,
  input  logic [IDLE_W-1:0] idle_thr,
  output logic [N_CH-1:0]   gclk,
  output logic [N_CH-1:0]   ch_en,
  output logic [N_CH-1:0]   ch_rdy,
  output logic              all_gated,
  output logic [EVT_W-1:0]  gate_evt
);
  localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam int SW = EVT_W + $clog2(N_CH + 1);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;
  state_e            state_q [N_CH];
  state_e            state_d [N_CH];
  logic [IDLE_W-1:0] cnt_q [N_CH];
  logic [IDLE_W-1:0] cnt_d [N_CH];
  logic [WCW-1:0]    wcnt_q [N_CH];
  logic [WCW-1:0]    wcnt_d [N_CH];
  logic [N_CH-1:0]   act, enter_g, ch_en_d, ch_en_q, ch_rdy_d, ch_rdy_q;
  logic              all_gated_q;
  logic [EVT_W-1:0]  gate_evt_d, gate_evt_q;
  logic [SW-1:0]     evt_sum;
  assign act = busy | force_on;
  always_comb begin
    evt_sum = SW'(gate_evt_q);
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i] = cnt_q[i];
      wcnt_d[i] = wcnt_q[i];
      enter_g[i] = 1'b0;
      case (state_q[i])
        RUN:
          if (act[i] || idle_thr == '0) cnt_d[i] = '0;
          else if ({1'b0, cnt_q[i]} + 1'b1 >= {1'b0, idle_thr}) begin
            state_d[i] = GATED;
            cnt_d[i] = '0;
            enter_g[i] = 1'b1;
          end else cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
        GATED:
          if (act[i]) begin
            state_d[i] = (WAKE_CYC == 0) ? RUN : WAKE;
            wcnt_d[i] = WCW'(WAKE_CYC - 1);
          end
        WAKE:
          if (wcnt_q[i] == '0) state_d[i] = RUN;
          else wcnt_d[i] = wcnt_q[i] - 1'b1;
        default: state_d[i] = RUN;
      endcase
      ch_en_d[i] = state_d[i] != GATED;
      ch_rdy_d[i] = state_d[i] == RUN;
      evt_sum = evt_sum + SW'(enter_g[i]);
    end
    gate_evt_d = (evt_sum > SW'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= RUN;
        cnt_q[i] <= '0;
        wcnt_q[i] <= '0;
      end
      ch_en_q <= '1;
      ch_rdy_q <= '1;
      all_gated_q <= 1'b0;
      gate_evt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
        wcnt_q[i] <= wcnt_d[i];
      end
      ch_en_q <= ch_en_d;
      ch_rdy_q <= ch_rdy_d;
      all_gated_q <= ~|ch_en_d;
      gate_evt_q <= gate_evt_d;
    end
  assign ch_en = ch_en_q;
  assign ch_rdy = ch_rdy_q;
  assign all_gated = all_gated_q;
  assign gate_evt = gate_evt_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    iiitb_icg_cell u_cell (.clk(clk), .rst_n(rst_n), .en(ch_en_q[g]), .gclk(gclk[g]));
  end
endmodule

// File: doc/iiitb_icg_ctrl.md
Name: iiitb_icg_ctrl

Overview:
- Parametrised multi-channel clock-gating controller; successor to the single-enable ICG.
- Each channel watches a busy input and gates its own clock after a programmable number of idle cycles.
- Each channel wakes through a timed WAKE phase before it reports ready.
- Sits between the shared functional clock and the per-domain register banks; one glitch-free latch-based ICG cell per channel.

Parameters:
- N_CH, 4: number of gated clock channels.
- IDLE_W, 8: width of the idle threshold and of the per-channel idle counter.
- WAKE_CYC, 2: cycles spent in WAKE before ch_rdy rises; 0 means go straight to RUN.
- EVT_W, 16: width of the saturating gate-event counter.

Ports:
- clk  in  1  free-running functional clock.
- rst_n  in  1  reset, asynchronous, active-low.
- busy  in  N_CH  per-channel activity; 1 means the channel needs its clock.
- force_on  in  N_CH  per-channel override; 1 keeps or returns the channel to RUN.
- idle_thr  in  IDLE_W  number of consecutive idle samples before gating; 0 disables gating on all channels.
- gclk  out  N_CH  gated clocks.
- ch_en  out  N_CH  registered gate enable per channel.
- ch_rdy  out  N_CH  1 when the channel clock is running and stable (RUN state only).
- all_gated  out  1  1 when every ch_en is 0.
- gate_evt  out  EVT_W  saturating count of entries into GATED, summed over channels.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - every channel in RUN, idle counter 0, wake counter 0.
  - ch_en all 1, ch_rdy all 1, ICG latches forced to 1 (clocks run out of reset).
  - all_gated=0, gate_evt=0.
- Per-channel FSM, all transitions on clk rising edge; "active" = busy[i] | force_on[i]:
  - RUN: ch_en=1, ch_rdy=1.
    - active: cnt <= 0.
    - not active and idle_thr != 0 and cnt+1 >= idle_thr: go to GATED, cnt <= 0.
    - otherwise, if not active: cnt <= cnt+1, saturating at all-ones.
    - idle_thr=0: never gate; cnt is held at 0.
  - GATED: ch_en=0, ch_rdy=0.
    - active: go to WAKE, wcnt <= WAKE_CYC-1.
    - if WAKE_CYC=0, go directly to RUN instead.
  - WAKE: ch_en=1, ch_rdy=0.
    - wcnt decrements each edge; at wcnt=0 go to RUN.
    - busy dropping during WAKE does not abort it; the channel still completes WAKE, then counts idle in RUN.
- Latency:
  - busy low sampled on thr consecutive edges: ch_en low after the thr-th edge.
  - gclk stops from the next low phase of clk.
  - wake: ch_en high one edge after active is sampled; ch_rdy high WAKE_CYC edges later.
- idle_thr is sampled live.
  - Lowering it mid-count gates on the next edge where cnt+1 >= new value (>= compare, no missed threshold).
  - Raising it simply extends the count.
- force_on has the same effect as busy and wins over any idle count.
- ICG cell:
  - Latch transparent while clk=0 captures ch_en; gclk = clk & latch_q.
  - No glitch when ch_en changes while clk=1.
- gate_evt:
  - Adds popcount of channels entering GATED on this edge.
  - Saturates at 2^EVT_W-1 and never wraps.
- all_gated is registered from next-state enables, so it is coincident with ch_en.
- Simultaneous events: channels are fully independent; any mix of entries and exits in one cycle is legal.
- Reset asserted mid-WAKE or mid-count returns the channel immediately to the RUN reset values.

Decomposition:
- Shared package holds:
  - state enum (RUN=2'b00, GATED=2'b01, WAKE=2'b10);
  - default constants for IDLE_W, WAKE_CYC, EVT_W.
- Sub-module iiitb_icg_cell (latch + AND, async reset forces latch to 1), instantiated once per channel.
- FSM, counters and the event adder stay in the top module.

Test Plan:
- Reset release, busy=0, idle_thr=4: ch_en[i] falls after the 4th edge; gclk flat from then; ch_rdy=0; gate_evt=4 (all four channels); all_gated=1.
- Channel 1 gated, busy[1] pulses 1 for one cycle, WAKE_CYC=2: ch_en[1]=1 next edge; ch_rdy[1]=1 two edges later; channel 1 re-gates after 4 more idle edges; gate_evt increments to 5.
- idle_thr=0 with busy=0 for 100 cycles: no gating, ch_en=4'hF, gate_evt=0.
- idle_thr=200, counter at 10, idle_thr switched to 5: channel gates on the next edge.
- force_on[2]=1 while busy[2]=0: channel 2 stays in RUN indefinitely; dropping force_on gates it thr edges later.
- rst_n pulled low mid-WAKE and mid-clock-high: ch_en, ch_rdy and gclk enable return to 1 asynchronously with no runt pulse on gclk; gate_evt preloaded near max (EVT_W=4) saturates at 15.
